// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan bus: segment codes,
// anode selects and the decoder FSM states.
package ssd_pkg;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [3:0] DIG0  = 4'b1110;
  localparam logic [3:0] DIG1  = 4'b1101;
  localparam logic [3:0] DIG2  = 4'b1011;
  localparam logic [3:0] DIG3  = 4'b0111;
  localparam logic [3:0] BLANK = 4'b1111;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  function automatic logic [3:0] dig_sel(
    input logic [1:0] idx
  );
    logic [3:0] sel;
    sel = BLANK;
    unique case (idx)
      2'd0: sel = DIG0;
      2'd1: sel = DIG1;
      2'd2: sel = DIG2;
      2'd3: sel = DIG3;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/seg_to_hex.sv
// Inverse segment lookup: active-low g..a pattern to hex nibble,
// with a flag for patterns that are not one of the 16 digit glyphs.
module seg_to_hex
  import ssd_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_valid,
  output logic [3:0] o_nib
);

  always_comb begin
    o_valid = 1'b0;
    o_nib   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG_CODE[i]) begin
        o_valid = 1'b1;
        o_nib   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Recovers the 16-bit value shown on a scanned 4-digit seven-segment bus.
// Define SSD_SCAN_DECODER_DP_EN to also capture the decimal points.
module seven_segment_scan_decoder
  import ssd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int SETTLE_W      = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_Chosen_Segment,
  input  logic [7:0]  i_SevenSegment,
  output logic [15:0] o_Data,
  output logic        o_Valid,
  output logic        o_Error,
  output logic [3:0]  o_Dp
);

  logic [11:0]         r_sync1;
  logic [11:0]         r_sync2;
  logic [11:0]         r_prev;
  logic [SETTLE_W-1:0] r_cnt;

  state_t              r_state;
  state_t              w_state_n;
  logic [1:0]          r_idx;
  logic [1:0]          w_idx_n;
  logic [11:0]         r_nibs;
  logic                r_err;

  logic [3:0]          w_anode;
  logic [6:0]          w_seg;
  logic                w_same;
  logic                w_cap;
  logic                w_ok;
  logic [3:0]          w_nib;
  logic                w_start;
  logic                w_store;
  logic                w_commit;

  assign w_anode = r_sync2[11:8];
  assign w_seg   = r_sync2[6:0];
  assign w_same  = (r_sync2 == r_prev);
  assign w_cap   = w_same &&
                   (r_cnt == SETTLE_W'(SETTLE_CYCLES - 1));

  seg_to_hex u_dec (
    .i_seg   (w_seg),
    .o_valid (w_ok),
    .o_nib   (w_nib)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {i_Chosen_Segment, i_SevenSegment};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != SETTLE_W'(SETTLE_CYCLES))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
    end
  end

  // A digit-0 capture always (re)starts a frame, even mid-collection.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_start   = 1'b0;
    w_store   = 1'b0;
    w_commit  = 1'b0;
    if (w_cap) begin
      unique case (1'b1)
        (w_anode == BLANK): begin
        end
        (w_anode == DIG0): begin
          w_state_n = COLLECT;
          w_idx_n   = 2'd1;
          w_start   = 1'b1;
        end
        (r_state == COLLECT &&
         w_anode == dig_sel(r_idx)): begin
          if (r_idx == 2'd3) begin
            w_commit  = 1'b1;
            w_state_n = IDLE;
            w_idx_n   = '0;
          end else begin
            w_store = 1'b1;
            w_idx_n = r_idx + 2'd1;
          end
        end
        default: begin
          w_state_n = IDLE;
          w_idx_n   = '0;
        end
      endcase
    end
  end

  // Three shifts per frame leave digit 0 in the low nibble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nibs  <= '0;
      r_err   <= 1'b0;
      o_Data  <= '0;
      o_Error <= 1'b0;
      o_Valid <= 1'b0;
    end else begin
      o_Valid <= w_commit;
      if (w_start || w_store)
        r_nibs <= {w_nib, r_nibs[11:4]};
      if (w_start)
        r_err <= ~w_ok;
      else if (w_store)
        r_err <= r_err | ~w_ok;
      if (w_commit) begin
        o_Data  <= {w_nib, r_nibs};
        o_Error <= r_err | ~w_ok;
      end
    end
  end

`ifdef SSD_SCAN_DECODER_DP_EN
  logic [2:0] r_dps;
  logic       w_dp;

  assign w_dp = ~r_sync2[7];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dps <= '0;
      o_Dp  <= '0;
    end else begin
      if (w_start || w_store)
        r_dps <= {w_dp, r_dps[2:1]};
      if (w_commit)
        o_Dp <= {w_dp, r_dps};
    end
  end
`else
  assign o_Dp = 4'b0000;
`endif

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Bench for seven_segment_scan_decoder: vector table, corner sequences
// and random frames against a lookup-based frame model.
module tb_seven_segment_scan_decoder;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an = 4'hF;
  logic [7:0]  seg = 8'hFF;
  logic [15:0] o_Data;
  logic        o_Valid;
  logic        o_Error;
  logic [3:0]  o_Dp;

  int total = 0;
  int bad = 0;
  int vcnt = 0;

  logic [6:0] codes [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [15:0] val;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [15:0] ed;
    logic        ee;
    logic [3:0]  edp;
  } vec_t;

  vec_t tbl [6];

  seven_segment_scan_decoder #(
    .SETTLE_CYCLES (S),
    .SETTLE_W      (5)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_Chosen_Segment (an),
    .i_SevenSegment   (seg),
    .o_Data           (o_Data),
    .o_Valid          (o_Valid),
    .o_Error          (o_Error),
    .o_Dp             (o_Dp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_Valid) vcnt++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] enc(input logic [3:0] n,
                                     input logic dp);
    return {~dp, codes[n]};
  endfunction

  function automatic logic [3:0] dp_exp(input logic [3:0] d);
`ifdef SSD_SCAN_DECODER_DP_EN
    return d;
`else
    return 4'b0000 & d;
`endif
  endfunction

  // {dp, err, data} a complete frame of four segment bytes should yield
  function automatic logic [20:0] model(input logic [31:0] segs);
    logic [15:0] d;
    logic        e;
    logic [3:0]  p;
    logic [7:0]  s;
    int          f;
    d = '0; e = 1'b0; p = '0;
    for (int k = 0; k < 4; k++) begin
      s = segs[k*8 +: 8];
      f = -1;
      for (int i = 0; i < 16; i++)
        if (s[6:0] == codes[i]) f = i;
      if (f < 0) e = 1'b1;
      else d[k*4 +: 4] = 4'(f);
      p[k] = ~s[7];
    end
    return {dp_exp(p), e, d};
  endfunction

  function automatic logic [3:0] sel(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [7:0] s,
                       input int n);
    an = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input string nm, input logic [31:0] segs,
                       input int hold, input logic [20:0] exp);
    int v0;
    v0 = vcnt;
    for (int k = 0; k < 4; k++) drive(sel(k), segs[k*8 +: 8], hold);
    drive(4'hF, 8'hFF, 8);
    chk({nm, " valid"}, vcnt - v0, 1);
    chk({nm, " data"}, o_Data, exp[15:0]);
    chk({nm, " err"}, o_Error, exp[16]);
    chk({nm, " dp"}, o_Dp, exp[20:17]);
  endtask

  initial begin
    logic [31:0] segs;
    int          v0;
    int          lat;

    tbl[0] = '{16'h1234, 4'b0000, 4'b0000, 16'h1234, 1'b0, 4'b0000};
    tbl[1] = '{16'hABCD, 4'b0000, 4'b0100, 16'hA0CD, 1'b1, 4'b0000};
    tbl[2] = '{16'hBEEF, 4'b0000, 4'b0000, 16'hBEEF, 1'b0, 4'b0000};
    tbl[3] = '{16'hA5A5, 4'b1000, 4'b0000, 16'hA5A5, 1'b0, 4'b1000};
    tbl[4] = '{16'h0000, 4'b1111, 4'b0000, 16'h0000, 1'b0, 4'b1111};
    tbl[5] = '{16'hFFFF, 4'b0000, 4'b1001, 16'h0FF0, 1'b1, 4'b0000};

    repeat (3) @(negedge clk);
    chk("rst data", o_Data, 0);
    chk("rst valid", o_Valid, 0);
    chk("rst err", o_Error, 0);
    chk("rst dp", o_Dp, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 4; k++)
        segs[k*8 +: 8] = tbl[t].blank[k] ? 8'hFF :
                         enc(tbl[t].val[k*4 +: 4], tbl[t].dp[k]);
      frame($sformatf("vec%0d", t), segs, 64,
            {dp_exp(tbl[t].edp), tbl[t].ee, tbl[t].ed});
    end

    // glitching digit 1 before it settles on '3'
    v0 = vcnt;
    drive(sel(0), enc(4'h4, 0), 64);
    drive(sel(1), enc(4'h1, 0), 1);
    drive(sel(1), enc(4'h7, 0), 1);
    drive(sel(1), enc(4'h8, 0), 1);
    drive(sel(1), enc(4'h3, 0), 64);
    drive(sel(2), enc(4'h2, 0), 64);
    drive(sel(3), enc(4'h1, 0), 64);
    drive(4'hF, 8'hFF, 8);
    chk("glitch valid", vcnt - v0, 1);
    chk("glitch data", o_Data, 16'h1234);

    // out-of-order and non-one-hot anodes abort the frame
    v0 = vcnt;
    drive(DIG(0), enc(4'h0, 0), 64);
    drive(4'b1011, enc(4'h0, 0), 64);
    drive(4'b0111, enc(4'h0, 0), 64);
    drive(sel(0), enc(4'h1, 0), 64);
    drive(sel(1), enc(4'h1, 0), 64);
    drive(4'b0011, enc(4'h1, 0), 64);
    drive(sel(2), enc(4'h1, 0), 64);
    drive(sel(3), enc(4'h1, 0), 64);
    drive(4'hF, 8'hFF, 8);
    chk("abort valid", vcnt - v0, 0);
    chk("abort hold", o_Data, 16'h1234);
    frame("beef", {enc(4'hB,0), enc(4'hE,0), enc(4'hE,0), enc(4'hF,0)},
          64, model({enc(4'hB,0), enc(4'hE,0),
                     enc(4'hE,0), enc(4'hF,0)}));

    // reset mid-frame
    drive(sel(0), enc(4'hF, 0), 30);
    drive(sel(1), enc(4'h0, 0), 30);
    rst_n = 1'b0;
    #1;
    chk("midrst data", o_Data, 0);
    chk("midrst err", o_Error, 0);
    chk("midrst dp", o_Dp, 0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = vcnt;
    drive(sel(2), enc(4'hF, 0), 30);
    drive(sel(3), enc(4'h0, 0), 30);
    drive(4'hF, 8'hFF, 8);
    chk("partial valid", vcnt - v0, 0);
    chk("partial data", o_Data, 0);
    frame("0f0f", {enc(4'h0,0), enc(4'hF,0), enc(4'h0,0), enc(4'hF,0)},
          64, {4'b0000, 1'b0, 16'h0F0F});

    // commit latency from digit 3 appearing on the pins
    drive(sel(0), enc(4'h8, 0), 30);
    drive(sel(1), enc(4'h7, 0), 30);
    drive(sel(2), enc(4'h6, 0), 30);
    an = sel(3);
    seg = enc(4'h5, 0);
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (o_Valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, S + 3);
    drive(4'hF, 8'hFF, 8);
    chk("latency data", o_Data, 16'h5678);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 7) == 0)
          segs[k*8 +: 8] = 8'($urandom);
        else
          segs[k*8 +: 8] = enc(4'($urandom), 1'($urandom));
      end
      frame($sformatf("rnd%0d", r), segs,
            $urandom_range(S + 4, S + 24), model(segs));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [3:0] DIG(input int k);
    return sel(k);
  endfunction

endmodule
